// File: rtl/aline_readout_if.sv
`default_nettype none
// ------------------------------------------------------------------
// aline_readout_if : sample-RAM read port and output word stream. Rev 1.0
// ------------------------------------------------------------------
interface aline_readout_if;
  logic [10:0] ram_rd_addr;
  logic [13:0] ram_rd_data;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_sop;
  logic        out_eop;
  logic        out_ready;

  modport master (
    output ram_rd_addr,
    input  ram_rd_data,
    output out_data,
    output out_valid,
    output out_sop,
    output out_eop,
    input  out_ready
  );

  modport slave (
    input  ram_rd_addr,
    output ram_rd_data,
    input  out_data,
    input  out_valid,
    input  out_sop,
    input  out_eop,
    output out_ready
  );
endinterface
`default_nettype wire

// File: rtl/aline_readout.sv
`default_nettype none
// ------------------------------------------------------------------
// aline_readout : streams one A-line from sample RAM per acq_busy fall.
// ALINE_HEADER_EN adds a leading header word per A-line. Rev 1.0
// ------------------------------------------------------------------
module aline_readout #(
  parameter logic [10:0] NSAMPLES = 11'd1170,
  parameter int          RD_LAT   = 2
) (
  input  wire logic       ADC_data_out_clk,
  input  wire logic       global_reset_n,
  input  wire logic       acq_busy,
  aline_readout_if.master bus,
  output logic            rd_busy,
  output logic [15:0]     aline_count,
  output logic [7:0]      drop_count,
  output logic            overrun
);

  localparam int DEPTH = RD_LAT + 2;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CREDIT_LIMIT = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_LAST     = PW'(DEPTH - 1);
  localparam logic [10:0]   LAST_SAMPLE  = NSAMPLES - 11'd1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] HDR   = 2'd1;
  localparam logic [1:0] READ  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              acq_busy_q;
  logic [10:0]       addr_q, addr_d;
  logic [RD_LAT-1:0] pipe_q, pipe_d;
  logic [CW-1:0]     credit_q, credit_d;
  logic [13:0]       fifo_mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     fifo_cnt_q, fifo_cnt_d;
  logic [10:0]       ld_cnt_q, ld_cnt_d;
  logic [15:0]       out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_sop_q, out_sop_d;
  logic              out_eop_q, out_eop_d;
  logic [15:0]       aline_cnt_q, aline_cnt_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;
  logic              overrun_q, overrun_d;

  logic        ready_evt, drop_evt, xfer, out_free;
  logic        issue, issue_last, ret, fifo_empty;
  logic        pop, bypass, fifo_wr, ld_sample, eop_done;
  logic [13:0] sample;

  assign ready_evt  = acq_busy_q & ~acq_busy;
  assign drop_evt   = ready_evt & (state_q != IDLE);
  assign xfer       = out_valid_q & bus.out_ready;
  assign out_free   = ~out_valid_q | bus.out_ready;
  assign issue      = (state_q == READ) && (credit_q < CREDIT_LIMIT);
  assign issue_last = issue && (addr_q == LAST_SAMPLE);
  assign ret        = pipe_q[RD_LAT-1];
  assign fifo_empty = (fifo_cnt_q == '0);
  // Returning data bypasses the FIFO only when nothing older is queued.
  assign pop        = out_free & ~fifo_empty;
  assign bypass     = ret & out_free & fifo_empty;
  assign fifo_wr    = ret & ~bypass;
  assign ld_sample  = pop | bypass;
  assign sample     = pop ? fifo_mem_q[rd_ptr_q] : bus.ram_rd_data;
  assign eop_done   = xfer & out_eop_q;

  always_ff @(posedge ADC_data_out_clk or negedge global_reset_n) begin
    if (!global_reset_n) state_q <= IDLE;
    else                 state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (ready_evt) begin
`ifdef ALINE_HEADER_EN
          state_d = HDR;
`else
          state_d = READ;
`endif
        end
      end
      HDR: begin
`ifdef ALINE_HEADER_EN
        if (xfer) state_d = READ;
`else
        state_d = IDLE;
`endif
      end
      READ:    if (issue_last) state_d = DRAIN;
      DRAIN:   if (eop_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d      = addr_q;
    credit_d    = credit_q + CW'(issue) - CW'(pop | bypass);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fifo_cnt_d  = fifo_cnt_q + CW'(fifo_wr) - CW'(pop);
    ld_cnt_d    = ld_cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    aline_cnt_d = aline_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    overrun_d   = overrun_q;

    if (state_q == IDLE)  addr_d = '0;
    else if (issue_last)  addr_d = '0;
    else if (issue)       addr_d = addr_q + 11'd1;

    pipe_d[0] = issue;
    for (int i = 1; i < RD_LAT; i++) pipe_d[i] = pipe_q[i-1];

    if (fifo_wr) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
    if (pop)     rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);

    if (xfer) begin
      out_valid_d = 1'b0;
      out_sop_d   = 1'b0;
      out_eop_d   = 1'b0;
    end
    if (ld_sample) begin
      out_valid_d = 1'b1;
      out_data_d  = {2'b00, sample};
`ifdef ALINE_HEADER_EN
      out_sop_d   = 1'b0;
`else
      out_sop_d   = (ld_cnt_q == 11'd0);
`endif
      out_eop_d   = (ld_cnt_q == LAST_SAMPLE);
      ld_cnt_d    = ld_cnt_q + 11'd1;
    end
`ifdef ALINE_HEADER_EN
    if ((state_q == HDR) && !out_valid_q) begin
      out_valid_d = 1'b1;
      out_data_d  = {2'b10, aline_cnt_q[13:0]};
      out_sop_d   = 1'b1;
      out_eop_d   = 1'b0;
    end
`endif
    if (state_q == IDLE) ld_cnt_d = '0;

    if (eop_done) aline_cnt_d = aline_cnt_q + 16'd1;
    if (drop_evt) begin
      if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge ADC_data_out_clk or negedge global_reset_n) begin
    if (!global_reset_n) begin
      acq_busy_q  <= 1'b0;
      addr_q      <= '0;
      pipe_q      <= '0;
      credit_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      ld_cnt_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      aline_cnt_q <= '0;
      drop_cnt_q  <= '0;
      overrun_q   <= 1'b0;
    end else begin
      acq_busy_q  <= acq_busy;
      addr_q      <= addr_d;
      pipe_q      <= pipe_d;
      credit_q    <= credit_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
      ld_cnt_q    <= ld_cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      aline_cnt_q <= aline_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      overrun_q   <= overrun_d;
    end
  end

  // Storage only; emptiness is tracked by fifo_cnt_q.
  always_ff @(posedge ADC_data_out_clk) begin
    if (fifo_wr) fifo_mem_q[wr_ptr_q] <= bus.ram_rd_data;
  end

  assign bus.ram_rd_addr = addr_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_sop     = out_sop_q;
  assign bus.out_eop     = out_eop_q;
  assign rd_busy         = (state_q != IDLE);
  assign aline_count     = aline_cnt_q;
  assign drop_count      = drop_cnt_q;
  assign overrun         = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_aline_readout.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_aline_readout : randomized self-checking bench for aline_readout. Rev 1.0
// ------------------------------------------------------------------
module tb_aline_readout;

  localparam int RD_LAT = 2;
  localparam int NS     = 1170;
`ifdef ALINE_HEADER_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif
  localparam int EXP_LAT = HDR_EN ? 2 : RD_LAT + 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        acq_busy;
  logic        out_ready;
  logic        rd_busy;
  logic [15:0] aline_count;
  logic [7:0]  drop_count;
  logic        overrun;

  aline_readout_if bus();
  assign bus.out_ready = out_ready;

  aline_readout #(.NSAMPLES(11'(NS)), .RD_LAT(RD_LAT)) dut (
    .ADC_data_out_clk (clk),
    .global_reset_n   (rst_n),
    .acq_busy         (acq_busy),
    .bus              (bus),
    .rd_busy          (rd_busy),
    .aline_count      (aline_count),
    .drop_count       (drop_count),
    .overrun          (overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // RAM model: data for an address appears RD_LAT clocks later.
  logic [13:0] mem [2048];
  logic [13:0] rpipe [RD_LAT];
  always @(posedge clk) begin
    rpipe[0] <= mem[bus.ram_rd_addr];
    for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign bus.ram_rd_data = rpipe[RD_LAT-1];

  // Reference: each accepted A-line is a list of {is_hdr, sop, eop, data}.
  logic [18:0] exp_q [$];
  logic [15:0] model_count = 16'd0;
  int          model_drop  = 0;
  bit          model_ovr   = 1'b0;
  int          line_words  = 0;

  function automatic void push_line();
    if (HDR_EN) exp_q.push_back({1'b1, 1'b1, 1'b0, 2'b10, model_count[13:0]});
    for (int i = 0; i < NS; i++)
      exp_q.push_back({1'b0, (!HDR_EN && i == 0), (i == NS - 1), 2'b00, mem[i]});
  endfunction

  // Ready driver: 0 = always ready, 1 = random 50%, 2 = stall on a pending eop.
  int rdy_mode = 0;
  bit hold_eop = 1'b0;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        1:       out_ready = ($urandom_range(0, 1) == 1);
        2:       out_ready = !(hold_eop && bus.out_valid && bus.out_eop);
        default: out_ready = 1'b1;
      endcase
    end
  end

  int          cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit          contig_en = 1'b0;
  bit          prev_stall = 1'b0;
  bit          last_was_sample = 1'b0;
  int          last_cyc = 0;
  logic [17:0] prev_word;

  always @(negedge clk) begin
    logic [17:0] obs;
    logic [18:0] e;
    obs = {bus.out_sop, bus.out_eop, bus.out_data};
    if (!rst_n) begin
      prev_stall = 1'b0;
      last_was_sample = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 32'(bus.out_valid), 32'd1);
        chk("stall_word", 32'(obs), 32'(prev_word));
      end
      if (bus.out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_word", 32'(bus.out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("word", 32'(obs), 32'(e[17:0]));
          if (contig_en && last_was_sample && !e[18])
            chk("contig", 32'(cyc - last_cyc), 32'd1);
          last_cyc = cyc;
          last_was_sample = !e[18] && !e[16];
          if (e[16]) begin
            model_count = model_count + 16'd1;
            line_words = 0;
          end else begin
            line_words++;
          end
        end
      end
      prev_stall = bus.out_valid && !out_ready;
      prev_word  = obs;
    end
  end

  task automatic start_line();
    push_line();
    @(posedge clk); #2 acq_busy = 1'b1;
    repeat (3) @(posedge clk);
    #2 acq_busy = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit ok = 1'b0;
    for (int k = 0; k < 20000; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !rd_busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, 32'(ok), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_words(input int n, input string tag);
    bit ok = 1'b0;
    for (int k = 0; k < 20000; k++) begin
      @(negedge clk);
      if (line_words >= n) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_aline_count"}, 32'(aline_count), 32'(model_count));
    chk({tag, "_drop_count"}, 32'(drop_count), 32'(model_drop));
    chk({tag, "_overrun"}, 32'(overrun), 32'(model_ovr));
    chk({tag, "_rd_busy"}, 32'(rd_busy), 32'd0);
    chk({tag, "_addr_idle"}, 32'(bus.ram_rd_addr), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_sop"}, 32'(bus.out_sop), 32'd0);
    chk({tag, "_eop"}, 32'(bus.out_eop), 32'd0);
    chk({tag, "_data"}, 32'(bus.out_data), 32'd0);
    chk({tag, "_addr"}, 32'(bus.ram_rd_addr), 32'd0);
    chk({tag, "_rd_busy"}, 32'(rd_busy), 32'd0);
    chk({tag, "_aline_count"}, 32'(aline_count), 32'd0);
    chk({tag, "_drop_count"}, 32'(drop_count), 32'd0);
    chk({tag, "_overrun"}, 32'(overrun), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n    = 1'b0;
    acq_busy = 1'b0;
    for (int i = 0; i < 2048; i++) mem[i] = 14'(i);
    repeat (3) @(posedge clk);
    #2 check_all_zero("reset");
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Address-valued RAM, continuous ready: latency and one word per clock.
    contig_en = 1'b1;
    start_line();
    n = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (bus.out_valid) break;
    end
    chk("first_word_latency", 32'(n), 32'(EXP_LAT));
    wait_done("line1_done");
    contig_en = 1'b0;
    check_status("line1");

    // Random RAM contents, random back-pressure.
    for (int i = 0; i < NS; i++) mem[i] = 14'($urandom);
    rdy_mode = 1;
    start_line();
    wait_done("line2_done");
    check_status("line2");

    // Second ready event mid-line is dropped; current line completes.
    start_line();
    wait_words(500, "line3_words");
    @(posedge clk); #2 acq_busy = 1'b1;
    repeat (3) @(posedge clk);
    #2 acq_busy = 1'b0;
    model_drop++;
    model_ovr = 1'b1;
    wait_done("line3_done");
    check_status("line3");

    // Ready event in the same clock as the eop acceptance counts as a drop.
    rdy_mode = 2;
    hold_eop = 1'b1;
    start_line();
    @(posedge clk); #2 acq_busy = 1'b1;
    n = 0;
    for (int k = 0; k < 20000; k++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_eop) begin
        n = 1;
        break;
      end
    end
    chk("line4_eop_pending", 32'(n), 32'd1);
    @(posedge clk); #2 hold_eop = 1'b0;
    @(posedge clk); #2 acq_busy = 1'b0;
    model_drop++;
    wait_done("line4_done");
    check_status("line4");

    // Reset mid-readout clears everything at once; next line starts clean.
    rdy_mode = 0;
    start_line();
    wait_words(300, "line5_words");
    @(posedge clk); #2 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    exp_q.delete();
    model_count = 16'd0;
    model_drop  = 0;
    model_ovr   = 1'b0;
    line_words  = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    rdy_mode = 1;
    start_line();
    wait_done("line6_done");
    check_status("line6");

    // Count wraps from 16'hFFFF to 0 on the next completion.
    @(posedge clk); #2 force dut.aline_cnt_q = 16'hFFFF;
    @(posedge clk); #2 release dut.aline_cnt_q;
    model_count = 16'hFFFF;
    chk("preset_ffff", 32'(aline_count), 32'hFFFF);
    start_line();
    wait_done("line7_done");
    check_status("wrap");

    // Count of 5 shows up in the header word when headers are enabled.
    @(posedge clk); #2 force dut.aline_cnt_q = 16'd5;
    @(posedge clk); #2 release dut.aline_cnt_q;
    model_count = 16'd5;
    start_line();
    wait_done("line8_done");
    check_status("line8");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aline_readout.md
ALINE_READOUT -- requirements
Module: aline_readout

Interface
REQ-001 SHALL have parameter NSAMPLES, default 11'd1170: samples per A-line read from RAM.
REQ-002 SHALL have parameter RD_LAT, default 2: RAM read latency in clocks, from address to data.
REQ-003 SHALL have ADC_data_out_clk, input, 1 bit: sole clock; all logic is on its rising edge.
REQ-004 SHALL have global_reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have acq_busy, input, 1 bit: high while the acquisition side writes an A-line into RAM.
REQ-006 SHALL have ram_rd_addr, output, 11 bits: RAM read address.
REQ-007 SHALL have ram_rd_data, input, 14 bits: RAM read data, valid RD_LAT clocks after its address.
REQ-008 SHALL have out_data, output, 16 bits: output stream word.
REQ-009 SHALL have out_valid, out_sop and out_eop, outputs, 1 bit each: word valid, first word of A-line, last word of A-line.
REQ-010 SHALL have out_ready, input, 1 bit: downstream accepts the word.
REQ-011 SHALL have rd_busy, output, 1 bit: readout in progress.
REQ-012 SHALL have aline_count, output, 16 bits: number of completed A-lines.
REQ-013 SHALL have drop_count, output, 8 bits: number of A-lines skipped.
REQ-014 SHALL have overrun, output, 1 bit: sticky flag, set when an A-line is skipped.

Function
REQ-015 SHALL detect the falling edge of acq_busy, using a registered copy, as the A-line-ready event.
REQ-016 SHALL use a state machine with states IDLE, HDR, READ and DRAIN.
REQ-017 SHALL move IDLE to HDR on the ready event when ALINE_HEADER_EN is defined, and IDLE to READ otherwise.
REQ-018 SHALL issue reads in READ at addresses 0 to NSAMPLES-1, one address per clock, only when a credit is available.
REQ-019 SHALL count outstanding reads plus skid-FIFO occupancy as credits used, with a limit of RD_LAT+2.
REQ-020 SHALL capture returning ram_rd_data into a skid FIFO of depth RD_LAT+2, which never overflows.
REQ-021 SHALL emit each sample as out_data = {2'b00, sample}.
REQ-022 SHALL enter DRAIN after the address NSAMPLES-1 is issued.
REQ-023 SHALL leave DRAIN for IDLE on acceptance of the word with out_eop set.
REQ-024 SHALL increment aline_count by 1 in the same clock as REQ-023, wrapping from 16'hFFFF to 0.
REQ-025 SHALL follow the handshake rule that a word transfers when out_valid and out_ready are both high.
REQ-026 SHALL hold out_data, out_sop and out_eop stable while out_valid is high and out_ready is low.
REQ-027 SHALL NOT lower out_valid before the word transfers.
REQ-028 SHALL hold out_valid low while out_ready is low only when no word is pending.
REQ-029 SHALL set out_eop only on the word carrying sample NSAMPLES-1.
REQ-030 SHALL set out_sop only on the first word of an A-line.
REQ-031 SHALL, with continuous out_ready, place the first sample on out_valid RD_LAT+1 clocks after entering READ.
REQ-032 SHALL, with continuous out_ready, deliver one sample per clock.
REQ-033 SHALL hold rd_busy high in every state other than IDLE.
REQ-034 SHALL, on a ready event while rd_busy is high, ignore the event.
REQ-035 SHALL, in that case, increment drop_count (saturating at 8'hFF) and set overrun.
REQ-036 SHALL treat a ready event in the same clock as the transition to IDLE as a drop.
REQ-037 SHALL hold ram_rd_addr at 0 while in IDLE.

Reset
REQ-038 SHALL, on global_reset_n low, immediately force the state machine to IDLE.
REQ-039 SHALL, on global_reset_n low, force ram_rd_addr, out_data and aline_count to 0.
REQ-040 SHALL, on global_reset_n low, force drop_count, out_valid, out_sop, out_eop, rd_busy and overrun to 0.
REQ-041 SHALL, on global_reset_n low, empty the skid FIFO and credit counter and clear the acq_busy edge register.
REQ-042 SHALL discard any partial A-line on reset mid-readout; no out_eop is produced for it.
REQ-043 SHALL clear overrun only by reset.

Configuration
REQ-044 SHALL, with ALINE_HEADER_EN defined, emit a header word in HDR of {2'b10, aline_count[13:0]} with out_sop=1, then move to READ on its acceptance.
REQ-045 SHALL, with ALINE_HEADER_EN defined, make the header the first word of each A-line and leave the first sample with out_sop=0.
REQ-046 SHALL, with ALINE_HEADER_EN undefined, omit HDR and set out_sop on sample 0.

Verification
REQ-047 SHALL cover: RAM preloaded with addr value, acq_busy 1->0, out_ready=1 -> 1170 words of values 0..1169 on consecutive clocks, eop on 1169, aline_count=1.
REQ-048 SHALL cover: out_ready toggled by a random 50% pattern -> same 1170 words in order, with no word lost or duplicated and words stable while stalled.
REQ-049 SHALL cover: second acq_busy falling edge at word 500 -> drop_count=1 and overrun=1, and the current A-line completes intact.
REQ-050 SHALL cover: reset asserted at word 300 -> all outputs 0 at once, then the next ready event yields a full A-line starting at sample 0.
REQ-051 SHALL cover: ALINE_HEADER_EN defined with aline_count=5 -> first word 16'h8005 with sop=1, followed by 1170 samples.
REQ-052 SHALL cover: aline_count preset via 65535 A-lines (or forced) -> next completion wraps the count to 0.
